// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared FSM encodings and counter-width helper for serial_subtractor.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t DONE  = 2'd2;

   // The counter must be able to hold WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : start/busy/done handshake and operand/result bus.
//               The ovf signal is present only when SERIAL_SUB_OVF_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_half_sub.sv
// ============================================================================
// Module      : half_subtractor
// Description : Single-bit half subtractor, diff = x ^ y, borrow = ~x & y.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module half_subtractor (
   input  wire logic x,
   input  wire logic y,
   output logic      diff,
   output logic      borrow
);

   assign diff   = x ^ y;
   assign borrow = ~x & y;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first.
//               Define SERIAL_SUB_OVF_EN to add the two's-complement ovf flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input wire logic          clk,
   input wire logic          rst_n,
   serial_subtractor_if.slave bus
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic             r_brw;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;
   logic             w_busy;
   logic             w_done;
   logic             w_d1;
   logic             w_b1;
   logic             w_d;
   logic             w_b2;
   logic             w_bn;
   logic [WIDTH-1:0] w_diff_shift;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_ovf;
`endif

   // Two chained half subtractors form the full-subtractor bit cell.
   half_subtractor u_hs_ab (
      .x      (r_a_sr[0]),
      .y      (r_b_sr[0]),
      .diff   (w_d1),
      .borrow (w_b1)
   );

   half_subtractor u_hs_brw (
      .x      (w_d1),
      .y      (r_brw),
      .diff   (w_d),
      .borrow (w_b2)
   );

   assign w_bn = w_b1 | w_b2;

   generate
      if (WIDTH == 1) begin : g_diff_w1
         assign w_diff_shift = w_d;
      end else begin : g_diff_wn
         assign w_diff_shift = {w_d, r_diff[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == LAST_CNT) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         SHIFT:   w_busy = 1'b1;
         DONE:    w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr       <= '0;
         r_b_sr       <= '0;
         r_brw        <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_ovf        <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_a_sr       <= bus.a;
                  r_b_sr       <= bus.b;
                  r_brw        <= 1'b0;
                  r_cnt        <= '0;
                  r_diff       <= '0;
                  r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf        <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               r_a_sr <= r_a_sr >> 1;
               r_b_sr <= r_b_sr >> 1;
               r_brw  <= w_bn;
               r_cnt  <= r_cnt + CNT_W'(1);
               r_diff <= w_diff_shift;
               if (r_cnt == LAST_CNT) begin
                  r_borrow_out <= w_bn;
`ifdef SERIAL_SUB_OVF_EN
                  // On the last bit the shift registers hold the operand MSBs and w_d is the result MSB.
                  r_ovf        <= (r_a_sr[0] ^ r_b_sr[0]) & (r_a_sr[0] ^ w_d);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.diff       = r_diff;
   assign bus.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf        = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_subtractor;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) ifc8 ();
   serial_subtractor_if #(.WIDTH(1)) ifc1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // n counts negedges after the accepting edge; done is expected on n == WIDTH+1.
   task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input bit inj,
                      input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
      int n;
      int busy_cyc;
      int done_at;
      @(negedge clk);
      ifc8.start = 1'b1; ifc8.a = x; ifc8.b = y;
      @(negedge clk);
      ifc8.start = 1'b0; ifc8.a = ~x; ifc8.b = ~y;
      n = 1; busy_cyc = 0; done_at = 0;
      while (done_at == 0 && n <= 20) begin
         if (ifc8.busy) busy_cyc++;
         if (ifc8.done) done_at = n;
         else begin
            if (inj && n == 3) begin
               ifc8.start = 1'b1; ifc8.a = 8'd5; ifc8.b = 8'd9;
            end else ifc8.start = 1'b0;
            @(negedge clk);
            n++;
         end
      end
      check({tag, "_busy_cycles"}, busy_cyc, 8);
      check({tag, "_done_at"}, done_at, 9);
      if (inj) begin
         ifc8.start = 1'b1; ifc8.a = 8'd0; ifc8.b = 8'd1;
      end
      @(negedge clk);
      ifc8.start = 1'b0;
      check({tag, "_done_width"}, ifc8.done, 1'b0);
      check({tag, "_idle_after"}, ifc8.busy, 1'b0);
      check({tag, "_diff"}, ifc8.diff, exp_d);
      check({tag, "_borrow"}, ifc8.borrow_out, exp_b);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ifc8.ovf, exp_o);
`else
      if (exp_o === 1'bx) $display("unexpected unknown ovf expectation");
`endif
   endtask

   task automatic op1(input string tag, input logic x, input logic y,
                      input logic exp_d, input logic exp_b, input logic exp_o);
      int n;
      int busy_cyc;
      int done_at;
      @(negedge clk);
      ifc1.start = 1'b1; ifc1.a = x; ifc1.b = y;
      @(negedge clk);
      ifc1.start = 1'b0; ifc1.a = ~x; ifc1.b = ~y;
      n = 1; busy_cyc = 0; done_at = 0;
      while (done_at == 0 && n <= 10) begin
         if (ifc1.busy) busy_cyc++;
         if (ifc1.done) done_at = n;
         else begin
            @(negedge clk);
            n++;
         end
      end
      check({tag, "_busy_cycles"}, busy_cyc, 1);
      check({tag, "_done_at"}, done_at, 2);
      @(negedge clk);
      check({tag, "_done_width"}, ifc1.done, 1'b0);
      check({tag, "_diff"}, ifc1.diff, exp_d);
      check({tag, "_borrow"}, ifc1.borrow_out, exp_b);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ifc1.ovf, exp_o);
`else
      if (exp_o === 1'bx) $display("unexpected unknown ovf expectation");
`endif
   endtask

   task automatic reset_mid_shift();
      bit saw_done;
      @(negedge clk);
      ifc8.start = 1'b1; ifc8.a = 8'd100; ifc8.b = 8'd37;
      @(negedge clk);
      ifc8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_busy_before", ifc8.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", ifc8.busy, 1'b0);
      check("rst_mid_done", ifc8.done, 1'b0);
      check("rst_mid_diff", ifc8.diff, 8'h00);
      check("rst_mid_borrow", ifc8.borrow_out, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (ifc8.done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ifc8.done || ifc8.busy) saw_done = 1'b1;
      end
      check("rst_mid_no_done", saw_done, 1'b0);
   endtask

   initial begin
      ifc8.start = 1'b0; ifc8.a = '0; ifc8.b = '0;
      ifc1.start = 1'b0; ifc1.a = '0; ifc1.b = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", ifc8.busy, 1'b0);
      check("reset_done", ifc8.done, 1'b0);
      check("reset_diff", ifc8.diff, 8'h00);
      check("reset_borrow", ifc8.borrow_out, 1'b0);
      check("reset_w1_diff", ifc1.diff, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset_ovf", ifc8.ovf, 1'b0);
`endif
      rst_n = 1'b1;

      op8("v100_37",  8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0);
      op8("v5_9",     8'd5,   8'd9,   1'b0, 8'hFC,  1'b1, 1'b0);
      op8("v0_1",     8'd0,   8'd1,   1'b0, 8'hFF,  1'b1, 1'b0);
      op8("v255_255", 8'd255, 8'd255, 1'b0, 8'h00,  1'b0, 1'b0);
      op8("v0_0",     8'd0,   8'd0,   1'b0, 8'h00,  1'b0, 1'b0);
      op8("ovf80_01", 8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1);
      op8("ovf10_01", 8'h10,  8'h01,  1'b0, 8'h0F,  1'b0, 1'b0);
      op8("ignore",   8'd100, 8'd37,  1'b1, 8'd63,  1'b0, 1'b0);

      reset_mid_shift();
      op8("post_rst", 8'd200, 8'd55,  1'b0, 8'd145, 1'b0, 1'b0);

      op1("w1_0_1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      op1("w1_1_0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      op1("w1_1_1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
